systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter data_size, default 8, element width of A and B.
REQ-002 SHALL have parameter drain_cycles, default 2, number of cycles to wait after the last skewed beat before signalling done.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1 bit: load beat offered.
REQ-006 SHALL have port load_ready, output, 1 bit: load beat accepted when load_valid and load_ready are both high at a clock edge.
REQ-007 SHALL have port load_a, input, 3*data_size bits: row k of A; element m in bits [data_size*m +: data_size].
REQ-008 SHALL have port load_b, input, 3*data_size bits: column k of B; element m = B[m][k], same packing.
REQ-009 SHALL have ports a1, a2, a3, output, data_size bits each: skewed row streams into array rows 1..3.
REQ-010 SHALL have ports b1, b2, b3, output, data_size bits each: skewed column streams into array columns 1..3.
REQ-011 SHALL have port array_clr, output, 1 bit: one-cycle clear pulse for array accumulators.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse; array results c1..c9 are final in that cycle.

Function
REQ-014 SHALL implement an FSM with states IDLE, LOAD, CLEAR, STREAM, DRAIN, DONE.
REQ-015 SHALL drive load_ready high only in IDLE and LOAD.
REQ-016 SHALL store accepted beat k (0..2, counted by a 2-bit beat counter) into A row k and B column k.
REQ-017 SHALL go IDLE->LOAD on the first accepted beat, and LOAD->CLEAR on the third accepted beat.
REQ-018 SHALL hold state and the beat count while load_valid is low in LOAD; there is no timeout.
REQ-019 SHALL assert array_clr for exactly the single CLEAR cycle, then go to STREAM.
REQ-020 SHALL make STREAM last exactly 5 cycles, t = 0..4, tracked by a step counter.
REQ-021 SHALL, in STREAM step t, drive a_i = A[i-1][t-(i-1)] and b_j = B[t-(j-1)][j-1] when the index is in 0..2, else 0.
REQ-022 SHALL drive a1..a3 and b1..b3 from registers with value 0 in every state other than STREAM.
REQ-023 SHALL spend exactly drain_cycles cycles in DRAIN; drain_cycles = 0 goes STREAM->DONE directly.
REQ-024 SHALL assert done for the one DONE cycle, then return to IDLE.
REQ-025 SHALL ignore load_valid outside IDLE/LOAD; it is not accepted, and stored matrices are unchanged until the next IDLE-accepted beat.
REQ-026 SHALL allow back-to-back jobs: a beat may be accepted in the cycle immediately after DONE.
REQ-027 SHALL pass data unmodified, with no arithmetic and no width change; operands are unsigned data_size bits.
REQ-028 SHALL fix end-to-end latency: with the 3rd beat accepted at edge E, array_clr is high in cycle E+1, t=0 is in cycle E+2, and done is high in cycle E+7+drain_cycles.

Reset
REQ-029 SHALL, on reset low, immediately set state to IDLE, counters to 0, stored A/B to 0, a*/b* to 0, and load_ready=1, busy=0, done=0, array_clr=0.
REQ-030 SHALL treat reset asserted mid-LOAD/STREAM/DRAIN as aborting the job: no done pulse, partial data discarded.

Structure
REQ-031 SHALL place the FSM state encoding, N=3, STREAM_LEN=5 and the default data_size in a shared package, systolic_pkg, used by the array top as well.
REQ-032 SHALL use one natural sub-module, skew_mux, which selects the element or 0 for a given stream index and step t; it is instanced 6 times.

Verification
REQ-033 SHALL cover: A=[[1,2,3],[4,5,6],[7,8,9]], B=identity -> a1 sequence over t=0..4 is 1,2,3,0,0; a3 is 0,0,7,8,9; b1 is 1,0,0,0,0; after done, array c1..c9 = 1..9.
REQ-034 SHALL cover: load_valid toggled 1,0,0,1,0,1 -> exactly 3 beats accepted, busy rises on the first, array_clr follows the 3rd by one cycle.
REQ-035 SHALL cover: reset pulled low at STREAM t=2 -> all outputs 0 within the same cycle, no done; a subsequent full job gives correct results.
REQ-036 SHALL cover: load_valid held high through STREAM -> load_ready=0 and stored A/B unchanged; A=B=all 255 gives a c per PE of 3*65025=195075.
REQ-037 SHALL cover: drain_cycles=0 and =2 -> done at E+7 and E+9 respectively; a back-to-back second job is accepted at E+8 / E+10.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and FSM encoding for the 3x3 systolic array slice
package systolic_pkg;
    localparam int N = 3;
    localparam int STREAM_LEN = 5;
    localparam int DATA_SIZE = 8;
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/skew_mux.sv
// skew_mux: selects element t-idx of a row/column vector, or 0 when disabled or out of range
module skew_mux
    import systolic_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int idx = 0
) (
    input  logic                   en,
    input  logic [2:0]             t,
    input  logic [N*data_size-1:0] vec,
    output logic [data_size-1:0]   elem
);
    logic [3:0] k;
    assign k = {1'b0, t} - 4'(idx);
    assign elem = !en       ? '0 :
                  k == 4'd0 ? vec[0 +: data_size] :
                  k == 4'd1 ? vec[data_size +: data_size] :
                  k == 4'd2 ? vec[2*data_size +: data_size] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads A rows / B columns over three beats and streams them skewed into a 3x3 array
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int drain_cycles = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [N*data_size-1:0] load_a,
    input  logic [N*data_size-1:0] load_b,
    output logic [data_size-1:0]   a1,
    output logic [data_size-1:0]   a2,
    output logic [data_size-1:0]   a3,
    output logic [data_size-1:0]   b1,
    output logic [data_size-1:0]   b2,
    output logic [data_size-1:0]   b3,
    output logic                   array_clr,
    output logic                   busy,
    output logic                   done
);
    localparam int DW = drain_cycles > 1 ? $clog2(drain_cycles) : 1;
    state_t state, nstate;
    logic [1:0] beat;
    logic [2:0] step, nstep;
    logic [DW-1:0] dcnt;
    logic [N-1:0][N*data_size-1:0] arow, bcol;
    logic [N-1:0][data_size-1:0] a_nxt, b_nxt, a_q, b_q;
    logic accept;
    assign load_ready = state == IDLE || state == LOAD;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign array_clr = state == CLEAR;
    assign accept = load_valid && load_ready;
    assign nstep = state == STREAM ? step + 3'd1 : 3'd0;
    assign {a3, a2, a1} = a_q;
    assign {b3, b2, b1} = b_q;
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = accept ? LOAD : IDLE;
            LOAD:    nstate = accept && beat == 2'd2 ? CLEAR : LOAD;
            CLEAR:   nstate = STREAM;
            STREAM:  nstate = step != 3'(STREAM_LEN - 1) ? STREAM : drain_cycles == 0 ? DONE : DRAIN;
            DRAIN:   nstate = dcnt == DW'(drain_cycles - 1) ? DONE : DRAIN;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
            step  <= '0;
            dcnt  <= '0;
            arow  <= '0;
            bcol  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= nstate;
            step  <= nstep;
            dcnt  <= state == DRAIN ? dcnt + 1'b1 : '0;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            if (accept) begin
                arow[beat] <= load_a;
                bcol[beat] <= load_b;
                beat       <= beat == 2'd2 ? 2'd0 : beat + 2'd1;
            end
        end
    end
    for (genvar i = 0; i < N; i++) begin : g_skew
        skew_mux #(.data_size(data_size), .idx(i)) u_a (
            .en(nstate == STREAM), .t(nstep), .vec(arow[i]), .elem(a_nxt[i])
        );
        skew_mux #(.data_size(data_size), .idx(i)) u_b (
            .en(nstate == STREAM), .t(nstep), .vec(bcol[i]), .elem(b_nxt[i])
        );
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed checks of the feeder with a behavioural 3x3 systolic array behind it
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    logic lv, lr, clr, busy, done;
    logic [23:0] la, lb;
    logic [7:0] a1, a2, a3, b1, b2, b3;
    logic lv0, lr0, clr0, busy0, done0;
    logic [23:0] la0, lb0;
    logic [7:0] a1_0, a2_0, a3_0, b1_0, b2_0, b3_0;
    logic [47:0] sv;
    int checks = 0;
    int failures = 0;
    assign sv = {a1, a2, a3, b1, b2, b3};
    systolic_feeder #(.data_size(8), .drain_cycles(2)) dut (
        .clk(clk), .reset(reset), .load_valid(lv), .load_ready(lr), .load_a(la), .load_b(lb),
        .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .array_clr(clr), .busy(busy), .done(done)
    );
    systolic_feeder #(.data_size(8), .drain_cycles(0)) dut0 (
        .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(lr0), .load_a(la0), .load_b(lb0),
        .a1(a1_0), .a2(a2_0), .a3(a3_0), .b1(b1_0), .b2(b2_0), .b3(b3_0),
        .array_clr(clr0), .busy(busy0), .done(done0)
    );
    logic [7:0] aw[3][4];
    logic [7:0] bw[4][3];
    logic [7:0] ah[3][3];
    logic [7:0] bv[3][3];
    logic [31:0] c[3][3];
    always_comb begin
        aw[0][0] = a1;
        aw[1][0] = a2;
        aw[2][0] = a3;
        bw[0][0] = b1;
        bw[0][1] = b2;
        bw[0][2] = b3;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                aw[i][j+1] = ah[i][j];
                bw[i+1][j] = bv[i][j];
            end
    end
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                c[i][j]  <= clr ? 32'd0 : c[i][j] + 32'(aw[i][j]) * 32'(bw[i][j]);
                ah[i][j] <= clr ? 8'd0 : aw[i][j];
                bv[i][j] <= clr ? 8'd0 : bw[i][j];
            end
    function automatic logic [23:0] pk(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        return {z, y, x};
    endfunction
    function automatic logic [47:0] st(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r,
                                       input logic [7:0] u, input logic [7:0] v, input logic [7:0] w);
        return {p, q, r, u, v, w};
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive_job(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2,
                             input logic [23:0] k0, input logic [23:0] k1, input logic [23:0] k2, input bit hold);
        lv = 1'b1; la = r0; lb = k0;
        tick;
        la = r1; lb = k1;
        tick;
        la = r2; lb = k2;
        tick;
        lv = hold; la = '0; lb = '0;
    endtask
    task automatic test_reset;
        reset = 1'b0;
        repeat (2) tick;
        checks++;
        if ({lr, busy, done, clr} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=1000", {lr, busy, done, clr});
        end
        checks++;
        if (sv !== 48'd0) begin
            failures++;
            $display("FAIL reset_streams got=%h exp=0", sv);
        end
        checks++;
        if ({lr0, busy0, done0, clr0, a1_0, b3_0} !== {4'b1000, 16'd0}) begin
            failures++;
            $display("FAIL reset_dut0 got=%h exp=%h", {lr0, busy0, done0, clr0, a1_0, b3_0}, {4'b1000, 16'd0});
        end
        reset = 1'b1;
        tick;
    endtask
    task automatic test_identity;
        logic [47:0] e[5];
        e = '{st(1,0,0,1,0,0), st(2,4,0,0,0,0), st(3,5,7,0,1,0), st(0,6,8,0,0,0), st(0,0,9,0,0,1)};
        drive_job(pk(1,2,3), pk(4,5,6), pk(7,8,9), pk(1,0,0), pk(0,1,0), pk(0,0,1), 1'b0);
        checks++;
        if ({clr, busy, lr} !== 3'b110) begin
            failures++;
            $display("FAIL id_clear got=%b exp=110", {clr, busy, lr});
        end
        for (int t = 0; t < 5; t++) begin
            tick;
            checks++;
            if (sv !== e[t]) begin
                failures++;
                $display("FAIL id_stream t=%0d got=%h exp=%h", t, sv, e[t]);
            end
        end
        for (int n = 0; n < 2; n++) begin
            tick;
            checks++;
            if ({done, sv} !== 49'd0) begin
                failures++;
                $display("FAIL id_drain n=%0d got=%h exp=0", n, {done, sv});
            end
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL id_done got=%b exp=1", done);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (c[i][j] !== 32'(3*i + j + 1)) begin
                    failures++;
                    $display("FAIL id_c%0d got=%0d exp=%0d", 3*i + j + 1, c[i][j], 3*i + j + 1);
                end
            end
    endtask
    task automatic test_back_to_back;
        int e[9];
        e = '{4, 9, 7, 13, 21, 16, 22, 33, 25};
        lv = 1'b1; la = pk(1,2,3); lb = pk(2,1,0);
        checks++;
        if (lr !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_in_done got=%b exp=0", lr);
        end
        tick;
        checks++;
        if ({lr, busy} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_idle got=%b exp=10", {lr, busy});
        end
        drive_job(pk(1,2,3), pk(4,5,6), pk(7,8,9), pk(2,1,0), pk(0,3,1), pk(1,0,2), 1'b0);
        repeat (7) tick;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_early_done got=%b exp=0", done);
        end
        tick;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done got=%b exp=1", done);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (c[i/3][i%3] !== 32'(e[i])) begin
                failures++;
                $display("FAIL b2b_c%0d got=%0d exp=%0d", i + 1, c[i/3][i%3], e[i]);
            end
        end
        tick;
    endtask
    task automatic test_handshake;
        logic [5:0] pat;
        logic [23:0] ra[3];
        logic [23:0] rb[3];
        logic [47:0] e[3];
        int k;
        pat = 6'b101001;
        ra = '{pk(11,12,13), pk(21,22,23), pk(31,32,33)};
        rb = '{pk(1,0,0), pk(0,1,0), pk(0,0,1)};
        e = '{st(11,0,0,1,0,0), st(12,21,0,0,0,0), st(13,22,31,0,1,0)};
        k = 0;
        for (int s = 0; s < 6; s++) begin
            lv = pat[s];
            la = pat[s] ? ra[k] : pk(99,99,99);
            lb = pat[s] ? rb[k] : pk(77,77,77);
            if (pat[s]) k++;
            checks++;
            if (lr !== 1'b1) begin
                failures++;
                $display("FAIL hs_ready s=%0d got=%b exp=1", s, lr);
            end
            tick;
            checks++;
            if ({busy, clr} !== {1'b1, s == 5}) begin
                failures++;
                $display("FAIL hs_state s=%0d got=%b exp=%b", s, {busy, clr}, {1'b1, s == 5});
            end
        end
        lv = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick;
            checks++;
            if (sv !== e[t]) begin
                failures++;
                $display("FAIL hs_stream t=%0d got=%h exp=%h", t, sv, e[t]);
            end
        end
        repeat (5) tick;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL hs_done got=%b exp=1", done);
        end
        tick;
    endtask
    task automatic test_reset_abort;
        int e[9];
        int seen;
        e = '{4, 9, 7, 13, 21, 16, 22, 33, 25};
        drive_job(pk(1,2,3), pk(4,5,6), pk(7,8,9), pk(2,1,0), pk(0,3,1), pk(1,0,2), 1'b0);
        repeat (3) tick;
        checks++;
        if (sv !== st(3,5,7,0,3,1)) begin
            failures++;
            $display("FAIL abort_t2 got=%h exp=%h", sv, st(3,5,7,0,3,1));
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({lr, busy, done, clr, sv} !== {4'b1000, 48'd0}) begin
            failures++;
            $display("FAIL abort_outputs got=%h exp=%h", {lr, busy, done, clr, sv}, {4'b1000, 48'd0});
        end
        repeat (2) tick;
        reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_quiet got=%0d exp=0", seen);
        end
        drive_job(pk(1,2,3), pk(4,5,6), pk(7,8,9), pk(2,1,0), pk(0,3,1), pk(1,0,2), 1'b0);
        repeat (8) tick;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL abort_rerun_done got=%b exp=1", done);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (c[i/3][i%3] !== 32'(e[i])) begin
                failures++;
                $display("FAIL abort_c%0d got=%0d exp=%0d", i + 1, c[i/3][i%3], e[i]);
            end
        end
        tick;
    endtask
    task automatic test_hold_valid;
        int bad;
        drive_job(pk(255,255,255), pk(255,255,255), pk(255,255,255),
                  pk(255,255,255), pk(255,255,255), pk(255,255,255), 1'b1);
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            if (lr !== 1'b0) bad++;
            tick;
        end
        lv = 1'b0;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_ready got=%0d exp=0", bad);
        end
        checks++;
        if ({done, lr} !== 2'b10) begin
            failures++;
            $display("FAIL hold_done got=%b exp=10", {done, lr});
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (c[i/3][i%3] !== 32'd195075) begin
                failures++;
                $display("FAIL hold_c%0d got=%0d exp=195075", i + 1, c[i/3][i%3]);
            end
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle got=%b exp=0", busy);
        end
    endtask
    task automatic test_drain0;
        logic [23:0] ra[3];
        logic [23:0] rb[3];
        ra = '{pk(1,2,3), pk(4,5,6), pk(7,8,9)};
        rb = '{pk(1,0,0), pk(0,1,0), pk(0,0,1)};
        for (int k = 0; k < 3; k++) begin
            lv0 = 1'b1; la0 = ra[k]; lb0 = rb[k];
            tick;
        end
        lv0 = 1'b0;
        checks++;
        if (clr0 !== 1'b1) begin
            failures++;
            $display("FAIL d0_clear got=%b exp=1", clr0);
        end
        repeat (5) tick;
        checks++;
        if ({done0, a3_0, b3_0} !== {1'b0, 8'd9, 8'd1}) begin
            failures++;
            $display("FAIL d0_t4 got=%h exp=%h", {done0, a3_0, b3_0}, {1'b0, 8'd9, 8'd1});
        end
        tick;
        checks++;
        if ({done0, lr0} !== 2'b10) begin
            failures++;
            $display("FAIL d0_done got=%b exp=10", {done0, lr0});
        end
        ra = '{pk(40,41,42), pk(50,51,52), pk(60,61,62)};
        lv0 = 1'b1; la0 = ra[0]; lb0 = rb[0];
        tick;
        checks++;
        if ({lr0, busy0, done0} !== 3'b100) begin
            failures++;
            $display("FAIL d0_idle got=%b exp=100", {lr0, busy0, done0});
        end
        tick;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL d0_b2b_accept got=%b exp=1", busy0);
        end
        for (int k = 1; k < 3; k++) begin
            la0 = ra[k]; lb0 = rb[k];
            tick;
        end
        lv0 = 1'b0;
        tick;
        checks++;
        if ({a1_0, a2_0, b1_0} !== {8'd40, 8'd0, 8'd1}) begin
            failures++;
            $display("FAIL d0_job2_t0 got=%h exp=%h", {a1_0, a2_0, b1_0}, {8'd40, 8'd0, 8'd1});
        end
        repeat (5) tick;
        checks++;
        if (done0 !== 1'b1) begin
            failures++;
            $display("FAIL d0_job2_done got=%b exp=1", done0);
        end
        tick;
    endtask
    initial begin
        lv = 1'b0; la = '0; lb = '0;
        lv0 = 1'b0; la0 = '0; lb0 = '0;
        test_reset;
        test_identity;
        test_back_to_back;
        test_handshake;
        test_reset_abort;
        test_hold_valid;
        test_drain0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
